// File: rtl/pp_acc_pkg.sv
// Shared types and helpers for the partial-product shift accumulator.
// Optional saturation is selected with the PP_ACC_SATURATE_EN macro.
package pp_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pp_state_e;

  // Counter width: clog2(n), but never narrower than one bit.
  function automatic int pp_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pp_sat_add.sv
// W-bit signed adder with signed-overflow detect.
// With PP_ACC_SATURATE_EN defined the sum clamps to the signed limits on overflow.
module pp_sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W-1:0] raw_sum;

  assign raw_sum = a_i + b_i;
  assign ovf_o   = (a_i[W-1] == b_i[W-1]) && (raw_sum[W-1] != a_i[W-1]);

`ifdef PP_ACC_SATURATE_EN
  // Both addends share a sign on overflow, so a_i's sign picks the limit.
  assign sum_o = !ovf_o    ? raw_sum :
                 a_i[W-1]  ? {1'b1, {(W-1){1'b0}}} :
                             {1'b0, {(W-1){1'b1}}};
`else
  assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/pp_shift_accumulator.sv
// Accumulates NUM_PP signed partial products, optionally shifting term i left by i.
// Saturating accumulation is enabled by defining PP_ACC_SATURATE_EN.
//
// Handshake: a term transfers on the rising clk edge where partial_product_valid
// and partial_product_ready are both high; ready is high only in ACCUM, and a
// start in the same cycle takes precedence and drops the offered term.
module pp_shift_accumulator
  import pp_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH,
  parameter int NUM_PP     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode_shift,
  input  logic [DATA_WIDTH-1:0] partial_product,
  input  logic                  partial_product_valid,
  output logic                  partial_product_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_ready,
  output logic                  overflow,
  output pp_state_e             state_dbg
);

  localparam int CW = pp_cnt_width(NUM_PP);

  generate
    if (ACC_WIDTH < DATA_WIDTH) begin : g_bad_acc
      $error("ACC_WIDTH must be >= DATA_WIDTH");
    end
    if (NUM_PP < 1) begin : g_bad_num
      $error("NUM_PP must be >= 1");
    end
  endgenerate

  pp_state_e             state_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [CW-1:0]         count_q;
  logic                  mode_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  ovf_q;

  logic signed [ACC_WIDTH-1:0] term_ext;
  logic signed [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH-1:0]        sum_d;
  logic                        add_ovf;
  logic                        last_term;

  assign term_ext  = ACC_WIDTH'(signed'(partial_product));
  // Bits pushed past the MSB are simply lost; they are not an overflow.
  assign term      = mode_q ? (term_ext << count_q) : term_ext;
  assign last_term = (count_q == CW'(NUM_PP - 1));

  pp_sat_add #(.W(ACC_WIDTH)) u_add (
    .a_i   (acc_q),
    .b_i   (term),
    .sum_o (sum_d),
    .ovf_o (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (start) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= mode_shift;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (partial_product_valid) begin
            acc_q   <= sum_d;
            count_q <= count_q + CW'(1);
            ovf_q   <= ovf_q | add_ovf;
            if (last_term) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign partial_product_ready = ready_q;
  assign result                = acc_q;
  assign result_ready          = done_q;
  assign overflow              = ovf_q;
  assign state_dbg             = state_q;

endmodule

// File: tb/tb_pp_shift_accumulator.sv
// Directed bench for pp_shift_accumulator across several parameter sets.
// Expected values are hand-computed; PP_ACC_SATURATE_EN selects the saturating results.
module tb_pp_shift_accumulator;
  import pp_acc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode_shift;
  logic [15:0] pp;
  logic        pp_valid;
  logic        start_a, start_b, start_c, start_d, start_e;

  logic        rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
  logic [31:0] res_a, res_b, res_c, res_e;
  logic [15:0] res_d;
  logic        rr_a, rr_b, rr_c, rr_d, rr_e;
  logic        ovf_a, ovf_b, ovf_c, ovf_d, ovf_e;
  pp_state_e   st_a, st_b, st_c, st_d, st_e;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // A: NUM_PP=2, 32-bit acc
  pp_shift_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(32), .NUM_PP(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode_shift(mode_shift),
    .partial_product(pp), .partial_product_valid(pp_valid),
    .partial_product_ready(rdy_a), .result(res_a), .result_ready(rr_a),
    .overflow(ovf_a), .state_dbg(st_a));

  // B: NUM_PP=16 for shift-and-add multiplication
  pp_shift_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(32), .NUM_PP(16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode_shift(mode_shift),
    .partial_product(pp), .partial_product_valid(pp_valid),
    .partial_product_ready(rdy_b), .result(res_b), .result_ready(rr_b),
    .overflow(ovf_b), .state_dbg(st_b));

  // C: NUM_PP=4 for abort/restart
  pp_shift_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(32), .NUM_PP(4)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .mode_shift(mode_shift),
    .partial_product(pp), .partial_product_valid(pp_valid),
    .partial_product_ready(rdy_c), .result(res_c), .result_ready(rr_c),
    .overflow(ovf_c), .state_dbg(st_c));

  // D: 16-bit acc for overflow
  pp_shift_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(16), .NUM_PP(2)) dut_d (
    .clk(clk), .reset(reset), .start(start_d), .mode_shift(mode_shift),
    .partial_product(pp), .partial_product_valid(pp_valid),
    .partial_product_ready(rdy_d), .result(res_d), .result_ready(rr_d),
    .overflow(ovf_d), .state_dbg(st_d));

  // E: NUM_PP=1
  pp_shift_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(32), .NUM_PP(1)) dut_e (
    .clk(clk), .reset(reset), .start(start_e), .mode_shift(mode_shift),
    .partial_product(pp), .partial_product_valid(pp_valid),
    .partial_product_ready(rdy_e), .result(res_e), .result_ready(rr_e),
    .overflow(ovf_e), .state_dbg(st_e));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] term);
    pp       = term;
    pp_valid = 1'b1;
    tick();
    pp_valid = 1'b0;
    pp       = '0;
  endtask

  initial begin
    reset = 1'b1; mode_shift = 1'b0; pp = '0; pp_valid = 1'b0;
    start_a = 0; start_b = 0; start_c = 0; start_d = 0; start_e = 0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_state_a", 32'(st_a), 32'(IDLE));
    chk("rst_res_a", res_a, 32'h0);
    chk("rst_flags_a", {29'b0, rdy_a, rr_a, ovf_a}, 32'h0);
    chk("rst_flags_b", {29'b0, rdy_b, rr_b, ovf_b}, 32'h0);

    // 1: plain sum 0x1234 + 0x5678
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t1_ready_accum", 32'(rdy_a), 32'h1);
    feed(16'h1234);
    chk("t1_rr_mid", 32'(rr_a), 32'h0);
    feed(16'h5678);
    chk("t1_res", res_a, 32'h0000_68AC);
    chk("t1_rr", 32'(rr_a), 32'h1);
    chk("t1_ovf", 32'(ovf_a), 32'h0);
    chk("t1_ready_done", 32'(rdy_a), 32'h0);
    feed(16'h0001);
    chk("t1_done_hold", res_a, 32'h0000_68AC);

    // 2: mixed signs, then two negatives
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t2_clear", res_a, 32'h0);
    chk("t2_rr_clear", 32'(rr_a), 32'h0);
    feed(16'h0800); feed(16'hFC00);
    chk("t2_res_a", res_a, 32'h0000_0400);
    start_a = 1'b1; tick(); start_a = 1'b0;
    feed(16'hFC00); feed(16'hFC00);
    chk("t2_res_b", res_a, 32'hFFFF_F800);
    chk("t2_ovf", 32'(ovf_a), 32'h0);
    chk("t2_rr", 32'(rr_a), 32'h1);

    // 3: shift-and-add 3*5 and -3*5
    mode_shift = 1'b1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    mode_shift = 1'b0;  // latched at start only
    for (int i = 0; i < 16; i++) begin
      feed(((16'h0005 >> i) & 16'h1) != 16'h0 ? 16'h0003 : 16'h0000);
      if (i == 14) chk("t3_rr_before_last", 32'(rr_b), 32'h0);
    end
    chk("t3_mul_pos", res_b, 32'h0000_000F);
    chk("t3_rr", 32'(rr_b), 32'h1);
    mode_shift = 1'b1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < 16; i++)
      feed(((16'h0005 >> i) & 16'h1) != 16'h0 ? 16'hFFFD : 16'h0000);
    chk("t3_mul_neg", res_b, 32'hFFFF_FFF1);
    chk("t3_ovf", 32'(ovf_b), 32'h0);
    mode_shift = 1'b0;

    // 4: 16-bit overflow
    start_d = 1'b1; tick(); start_d = 1'b0;
    feed(16'h7000);
    chk("t4_ovf_mid", 32'(ovf_d), 32'h0);
    feed(16'h7000);
    chk("t4_ovf", 32'(ovf_d), 32'h1);
`ifdef PP_ACC_SATURATE_EN
    chk("t4_res_sat", 32'(res_d), 32'h0000_7FFF);
`else
    chk("t4_res_wrap", 32'(res_d), 32'h0000_E000);
`endif

    // 5: abort with start+valid, then restart
    start_c = 1'b1; tick(); start_c = 1'b0;
    feed(16'h0001); feed(16'h0002);
    chk("t5_partial", res_c, 32'h0000_0003);
    start_c = 1'b1; pp = 16'h0010; pp_valid = 1'b1;
    tick();
    start_c = 1'b0; pp_valid = 1'b0; pp = '0;
    chk("t5_dropped", res_c, 32'h0);
    chk("t5_state", 32'(st_c), 32'(ACCUM));
    feed(16'h0001); feed(16'h0002); feed(16'h0003);
    chk("t5_rr_early", 32'(rr_c), 32'h0);
    feed(16'h0004);
    chk("t5_res", res_c, 32'h0000_000A);
    chk("t5_rr", 32'(rr_c), 32'h1);

    // NUM_PP=1: first term completes
    start_e = 1'b1; tick(); start_e = 1'b0;
    feed(16'h8000);
    chk("t1pp_res", res_e, 32'hFFFF_8000);
    chk("t1pp_rr", 32'(rr_e), 32'h1);

    // 6: reset in ACCUM, then in DONE, then terms in IDLE
    start_a = 1'b1; tick(); start_a = 1'b0;
    feed(16'h0055);
    reset = 1'b1; start_a = 1'b1; pp_valid = 1'b1; pp = 16'h0011;
    tick();
    reset = 1'b0; start_a = 1'b0; pp_valid = 1'b0; pp = '0;
    chk("t6_accum_rst_state", 32'(st_a), 32'(IDLE));
    chk("t6_accum_rst_out", {res_a[28:0], rdy_a, rr_a, ovf_a}, 32'h0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    feed(16'h0001); feed(16'h0002);
    chk("t6_pre_rr", 32'(rr_a), 32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_done_rst_state", 32'(st_a), 32'(IDLE));
    chk("t6_done_rst_res", res_a, 32'h0);
    chk("t6_done_rst_flags", {29'b0, rdy_a, rr_a, ovf_a}, 32'h0);
    pp = 16'h0005; pp_valid = 1'b1;
    tick(); tick();
    pp_valid = 1'b0; pp = '0;
    chk("t6_idle_ready", 32'(rdy_a), 32'h0);
    chk("t6_idle_res", res_a, 32'h0);
    chk("t6_idle_state", 32'(st_a), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
